// File: rtl/instr_pkg.sv
// instr_pkg
//   Definitions shared by the MIPS instruction encoder and decoder, so that both
//   agree on field widths, format codes and controller states.
//   Contents:
//     - field width constants (OP_W, REG_W, SHAMT_W, FUNC_W, IMM_W, TGT_W, WORD_W)
//     - fmt_e   : instruction format tag (R, I, J, illegal)
//     - state_e : burst controller states
package instr_pkg;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;
  localparam int TGT_W   = 26;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_pack.sv
// instruction_pack
//   Purely combinational packer: format tag plus decoded fields in, one 32-bit
//   MIPS instruction word out. Inverse of the instruction decoder.
//   Ports:
//     fmt      in  2   format tag (FMT_R / FMT_I / FMT_J / FMT_BAD)
//     op_code  in  6   opcode
//     Rs/Rt/Rd in  5   register fields
//     shift    in  5   shift amount
//     func     in  6   function code
//     imm      in  16  immediate
//     target   in  26  jump target
//     word     out 32  packed instruction (nop for an illegal format)
//     illegal  out 1   high when fmt is FMT_BAD
module instruction_pack
  import instr_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic [OP_W-1:0]    op_code,
  input  logic [REG_W-1:0]   Rs,
  input  logic [REG_W-1:0]   Rt,
  input  logic [REG_W-1:0]   Rd,
  input  logic [SHAMT_W-1:0] shift,
  input  logic [FUNC_W-1:0]  func,
  input  logic [IMM_W-1:0]   imm,
  input  logic [TGT_W-1:0]   target,
  output logic [WORD_W-1:0]  word,
  output logic               illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would infer a latch.
    word    = '0;
    illegal = 1'b0;
    case (fmt_e'(fmt))
      FMT_R:   word = {op_code, Rs, Rt, Rd, shift, func};
      FMT_I:   word = {op_code, Rs, Rt, imm};
      FMT_J:   word = {op_code, target};
      default: illegal = 1'b1;  // nop word, flag raised
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Burst writer that packs decoded MIPS fields into instruction words and
//   writes them to consecutive word addresses of instruction memory.
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     start, base_addr,count burst request (honoured only in IDLE)
//     in_valid / in_ready    field-bundle handshake
//     fmt, op_code, Rs, Rt, Rd, shift, func, imm, target   field bundle
//     mem_we, mem_addr, mem_data   registered memory write port
//     busy                   high while in RUN
//     done                   one-cycle pulse at end of burst
//     err                    sticky illegal-format flag, cleared by start
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    count,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          fmt,
  input  logic [OP_W-1:0]     op_code,
  input  logic [REG_W-1:0]    Rs,
  input  logic [REG_W-1:0]    Rt,
  input  logic [REG_W-1:0]    Rd,
  input  logic [SHAMT_W-1:0]  shift,
  input  logic [FUNC_W-1:0]   func,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TGT_W-1:0]    target,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_data_q, mem_data_d;

  logic [WORD_W-1:0]   packed_word;
  logic                packed_illegal;
  logic                accept;

  instruction_pack u_pack (
    .fmt     (fmt),
    .op_code (op_code),
    .Rs      (Rs),
    .Rt      (Rt),
    .Rd      (Rd),
    .shift   (shift),
    .func    (func),
    .imm     (imm),
    .target  (target),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // Ready depends only on controller state, never on in_valid.
  assign in_ready = (state_q == S_RUN) && (remaining_q != '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Word-align the burst base; masking keeps every input bit in use.
          addr_d      = base_addr & ~ADDR_W'(3);
          remaining_d = count;
          err_d       = 1'b0;
          state_d     = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_data_d  = packed_word;
          addr_d      = addr_q + ADDR_W'(4);  // wraps modulo 2^ADDR_W
          remaining_d = remaining_q - CNT_W'(1);
          if (packed_illegal) err_d = 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder
//   Directed bench for instruction_encoder. Each driven beat pushes its
//   expected {address, word} onto a scoreboard queue; a monitor pops and
//   compares whenever the encoder issues a memory write. Control outputs are
//   checked at fixed points in the directed sequence.
module tb_instruction_encoder;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  op_code;
  logic [4:0]  Rs, Rt, Rd, shift;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  wr_t sb[$];
  logic [31:0] exp_addr;

  instruction_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .op_code   (op_code),
    .Rs        (Rs),
    .Rt        (Rt),
    .Rd        (Rd),
    .shift     (shift),
    .func      (func),
    .imm       (imm),
    .target    (target),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_write_addr", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {32'h0, mem_addr}, {32'h0, e.addr});
        check("wr_data", {32'h0, mem_data}, {32'h0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    exp_addr  = b & 32'hFFFF_FFFC;
    tick();
    start     = 1'b0;
  endtask

  // Drives one beat (in_valid stays high afterwards; caller lowers it) and
  // records the expected write.
  task automatic send(input logic [1:0] f, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic [31:0] exp_data);
    wr_t e;
    fmt = f; op_code = op; Rs = rs; Rt = rt; Rd = rd;
    shift = sh; func = fn; imm = im; target = tg;
    in_valid = 1'b1;
    check("in_ready_before_beat", {63'h0, in_ready}, 64'h1);
    e.addr = exp_addr;
    e.data = exp_data;
    sb.push_back(e);
    exp_addr = exp_addr + 32'd4;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'h0, in_ready}, 64'h0);
    check({tag, "_mem_we"},   {63'h0, mem_we},   64'h0);
    check({tag, "_mem_addr"}, {32'h0, mem_addr}, 64'h0);
    check({tag, "_mem_data"}, {32'h0, mem_data}, 64'h0);
    check({tag, "_busy"},     {63'h0, busy},     64'h0);
    check({tag, "_done"},     {63'h0, done},     64'h0);
    check({tag, "_err"},      {63'h0, err},      64'h0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    fmt = '0; op_code = '0; Rs = '0; Rt = '0; Rd = '0; shift = '0; func = '0;
    imm = '0; target = '0; exp_addr = '0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // R-type single beat: add $3,$1,$2
    w0 = n_writes;
    do_start(32'h100, 16'd1);
    check("r_busy", {63'h0, busy}, 64'h1);
    send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0022_1820);
    in_valid = 1'b0;
    check("r_done", {63'h0, done}, 64'h1);
    check("r_mem_we", {63'h0, mem_we}, 64'h1);
    check("r_err", {63'h0, err}, 64'h0);
    tick();
    check("r_done_pulse_ends", {63'h0, done}, 64'h0);
    check("r_idle_not_ready", {63'h0, in_ready}, 64'h0);
    tick();
    check("r_write_count", 64'(n_writes - w0), 64'd1);

    // Mixed burst, back-to-back beats: addi, j, jr
    w0 = n_writes;
    do_start(32'h0, 16'd3);
    send(2'd1, 6'h08, 5'd0,  5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h2008_0005);
    check("mix_busy_mid", {63'h0, busy}, 64'h1);
    send(2'd2, 6'h02, 5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0000040, 32'h0800_0040);
    send(2'd0, 6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0, 26'h0, 32'h03E0_0008);
    in_valid = 1'b0;
    check("mix_done_with_last_we", {62'h0, done, mem_we}, 64'h3);
    tick(); tick();
    check("mix_write_count", 64'(n_writes - w0), 64'd3);

    // Stall and a start pulse during RUN that must be ignored
    w0 = n_writes;
    do_start(32'h200, 16'd2);
    send(2'd1, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0, 32'h8C85_0010);
    in_valid = 1'b0;
    tick();
    base_addr = 32'h900; count = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("stall_busy", {63'h0, busy}, 64'h1);
    check("stall_ready", {63'h0, in_ready}, 64'h1);
    send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h3FF_FFFF, 32'h0FFF_FFFF);
    in_valid = 1'b0;
    check("stall_done", {63'h0, done}, 64'h1);
    tick(); tick();
    check("stall_write_count", 64'(n_writes - w0), 64'd2);

    // Illegal format: nop written, sticky err
    w0 = n_writes;
    do_start(32'h300, 16'd1);
    send(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 32'h0);
    in_valid = 1'b0;
    check("bad_err_set", {63'h0, err}, 64'h1);
    check("bad_done", {63'h0, done}, 64'h1);
    tick(); tick(); tick();
    check("bad_err_sticky", {63'h0, err}, 64'h1);
    check("bad_write_count", 64'(n_writes - w0), 64'd1);

    // Zero count: done one cycle after start, no writes, err cleared
    w0 = n_writes;
    do_start(32'h400, 16'd0);
    check("zero_done", {63'h0, done}, 64'h1);
    check("zero_err_cleared", {63'h0, err}, 64'h0);
    check("zero_not_busy", {63'h0, busy}, 64'h0);
    tick();
    check("zero_done_ends", {63'h0, done}, 64'h0);
    tick();
    check("zero_write_count", 64'(n_writes - w0), 64'd0);

    // Address wrap; low address bits of base are ignored
    w0 = n_writes;
    do_start(32'hFFFF_FFFF, 16'd2);
    send(2'd1, 6'h0D, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'hABCD, 26'h0, 32'h3421_ABCD);
    send(2'd0, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'h0, 26'h0, 32'h0009_5100);
    in_valid = 1'b0;
    check("wrap_done", {63'h0, done}, 64'h1);
    tick(); tick();
    check("wrap_write_count", 64'(n_writes - w0), 64'd2);

    // Reset mid-burst: abort with no further writes and no done pulse
    w0 = n_writes;
    do_start(32'h500, 16'd4);
    send(2'd1, 6'h08, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h0001, 26'h0, 32'h2043_0001);
    // in_valid stays high with a fresh bundle while reset is applied
    imm = 16'h0002;
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    tick();
    reset = 1'b0;
    check("midreset_hold_we", {63'h0, mem_we}, 64'h0);
    tick();
    check("midreset_idle_ready", {63'h0, in_ready}, 64'h0);
    check("midreset_no_done", {63'h0, done}, 64'h0);
    in_valid = 1'b0;
    tick(); tick();
    check("midreset_write_count", 64'(n_writes - w0), 64'd1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

- Sequential counterpart of the instruction decoder: accepts decoded MIPS fields (opcode, Rs, Rt, Rd, shift, func, imm, target) plus a format tag and packs them into 32-bit instruction words.
- Writes the packed words, one per accepted beat, into instruction memory at consecutive word addresses. This is how the testbench and boot loader fill program memory.
- Runs as a counted burst controlled by a start/done handshake, with a valid/ready field input.

## Interface
Parameters:
- ADDR_W, 32, width of memory byte address
- CNT_W, 16, width of burst length counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a burst (honoured only in IDLE)
- base_addr  in  ADDR_W  first byte address of burst; bits [1:0] ignored (forced 0)
- count  in  CNT_W  number of words in burst
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- fmt  in  2  0=R, 1=I, 2=J, 3=illegal
- op_code  in  6  opcode
- Rs, Rt, Rd  in  5 each  register fields
- shift  in  5  shift amount
- func  in  6  function code
- imm  in  16  immediate
- target  in  26  jump target
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  write byte address
- mem_data  out  32  packed instruction word
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of burst
- err  out  1  sticky, set by illegal fmt during a burst

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On start: latch base_addr (low 2 bits zeroed) into addr_q, latch count into remaining, clear err.
  - If count=0, go to DONE. Otherwise go to RUN.
  - start arriving in RUN or DONE is ignored.
- **RUN**
  - in_ready = (remaining != 0).
  - A beat is accepted when in_valid && in_ready.
  - On an accepted beat: register the packed word and addr_q onto mem_data/mem_addr, assert mem_we next cycle, then addr_q += 4 and remaining -= 1.
  - When the last beat is accepted, go to DONE.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
  - The final mem_we coincides with the DONE cycle.
- **Packing**
  - R: {op_code, Rs, Rt, Rd, shift, func}
  - I: {op_code, Rs, Rt, imm}
  - J: {op_code, target}
  - Fields unused by the format are ignored.
- **Illegal fmt (3):** write 32'h0000_0000 (nop) at the address, set err, and still consume the beat and advance the address.
- **Address arithmetic:** modulo 2^ADDR_W; wrap from max word to 0 is silent.
- **Outside an accepted beat:** mem_we=0; mem_addr/mem_data hold their last value.

## Timing
- **Reset values:** state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0, remaining=0.
- **Reset mid-burst:** abort immediately. No further writes, err cleared, no done pulse.
- **Latency:**
  - Bundle accepted at edge k drives mem_we/addr/data during cycle k+1 (one-cycle registered latency).
  - Back-to-back beats give one write per cycle.
  - start at edge s: RUN and in_ready=1 from cycle s+1.
  - count=0: done pulses in cycle s+1.
- **in_ready** is combinational from state/remaining only, never from in_valid.
- **in_valid** low in RUN stalls the burst indefinitely; no timeout.
- **busy** = (state==RUN).

## Structure
- Shared package `instr_pkg`:
  - format codes FMT_R/FMT_I/FMT_J/FMT_BAD
  - field width constants (OP_W=6, REG_W=5, SHAMT_W=5, FUNC_W=6, IMM_W=16, TGT_W=26)
  - FSM state enum
- Decode and encode both import this package so field positions stay consistent.
- One sub-module: `instruction_pack`, purely combinational fmt+fields → 32-bit word plus illegal flag.
  - Inverse of the decoder; round-trip check pack→decode is a bench property.
- Top: FSM, counters, output registers.

## Test plan
- **R-type:** start base=0x100, count=1. Beat fmt=0, op=0, Rs=1, Rt=2, Rd=3, shift=0, func=0x20 → mem_we one cycle later, addr=0x100, data=0x00221820. done next cycle, err=0.
- **Mixed burst:** base=0x0, count=3, beats every cycle:
  - I-type addi op=0x08, Rs=0, Rt=8, imm=0x0005 → 0x20080005 @0x0
  - J-type op=0x02, target=0x0000040 → 0x08000040 @0x4
  - R-type jr op=0, Rs=31, func=0x08 → 0x03E00008 @0x8
  - Three consecutive writes; done in the cycle of the third.
- **Stall and ignored start:** in_valid toggled 1,0,0,1 with count=2 → exactly 2 writes at base, base+4. start pulsed during RUN is ignored.
- **Illegal fmt and zero count:**
  - fmt=3 with count=1 → data=0x00000000 written, err=1 and holds until the next start.
  - count=0 → no mem_we, done one cycle after start.
- **Wrap and reset:**
  - base=0xFFFFFFFC, count=2 → writes @0xFFFFFFFC then @0x00000000.
  - reset asserted after the first beat of a count=4 burst → no further mem_we, all outputs at reset values, in_ready=0.
